// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUConf operation codes, the arbiter state
// encoding and a helper that flags operation codes the ALU does not implement.
package alu_pkg;

    localparam logic [4:0] ALU_ADD      = 5'd0;
    localparam logic [4:0] ALU_SUB      = 5'd1;
    localparam logic [4:0] ALU_AND      = 5'd2;
    localparam logic [4:0] ALU_OR       = 5'd3;
    localparam logic [4:0] ALU_XOR      = 5'd4;
    localparam logic [4:0] ALU_NOR      = 5'd5;
    localparam logic [4:0] ALU_SLL      = 5'd6;
    localparam logic [4:0] ALU_SRL      = 5'd7;
    localparam logic [4:0] ALU_SRA      = 5'd8;
    localparam logic [4:0] ALU_SLT      = 5'd9;
    localparam logic [4:0] ALU_CONF_MAX = 5'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Codes above ALU_CONF_MAX have no ALU meaning; their result is forced to zero.
    function automatic logic conf_is_illegal(input logic [4:0] conf);
        return (conf > ALU_CONF_MAX);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request
// found searching upward from i_ptr and wrapping modulo N, as a one-hot grant
// plus its index. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    int w_pos;

    // Walk the requesters in rotated order; the first hit wins.
    always_comb begin
        o_gnt = {N{1'b0}};
        o_idx = {W{1'b0}};
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = W'(w_pos);
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NUM_REQ requesters.
// One operation is in flight at a time: IDLE picks a winner and registers its
// operands, EXEC lets the ALU settle on them and captures Result/Zero, RESP
// holds the response until the granted requester takes it.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no rotating pointer); undefined gives round-robin.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [5*NUM_REQ-1:0]    req_conf,
    input  logic [NUM_REQ-1:0]      req_sign,
    input  logic [32*NUM_REQ-1:0]   req_in1,
    input  logic [32*NUM_REQ-1:0]   req_in2,
    output logic [4:0]              alu_conf,
    output logic                    alu_sign,
    output logic [31:0]             alu_in1,
    output logic [31:0]             alu_in2,
    input  logic [31:0]             alu_result,
    input  logic                    alu_zero,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [GW-1:0]           grant_id
);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic                w_accept;
    logic                w_rsp_done;
    logic                w_illegal;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [GW-1:0]       w_idx;
    logic                w_any;
    logic [GW-1:0]       w_ptr;
    logic [NUM_REQ-1:0]  w_rsp_onehot;

    logic [4:0]          r_alu_conf;
    logic                r_alu_sign;
    logic [31:0]         r_alu_in1;
    logic [31:0]         r_alu_in2;
    logic [GW-1:0]       r_grant_id;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [31:0]         r_rsp_result;
    logic                r_rsp_zero;
    logic                r_rsp_err;
    logic                r_busy;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: searching always starts at requester 0.
    assign w_ptr = {GW{1'b0}};
`else
    logic [GW-1:0] r_ptr;

    // Rotate the search start to just past the requester whose response completed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= {GW{1'b0}};
        end else if (w_rsp_done) begin
            r_ptr <= (r_grant_id == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : r_grant_id + 1'b1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_illegal    = conf_is_illegal(r_alu_conf);
    assign w_rsp_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, acceptance strobe and the combinational ready vector.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;
        req_ready    = {NUM_REQ{1'b0}};
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    req_ready    = w_gnt;
                    w_next_state = EXEC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready[r_grant_id]) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand latch at acceptance, result capture in EXEC, response retire in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_conf   <= 5'd0;
            r_alu_sign   <= 1'b0;
            r_alu_in1    <= 32'd0;
            r_alu_in2    <= 32'd0;
            r_grant_id   <= {GW{1'b0}};
            r_rsp_valid  <= {NUM_REQ{1'b0}};
            r_rsp_result <= 32'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_conf <= req_conf[int'(w_idx) * 5 +: 5];
                r_alu_sign <= req_sign[w_idx];
                r_alu_in1  <= req_in1[int'(w_idx) * 32 +: 32];
                r_alu_in2  <= req_in2[int'(w_idx) * 32 +: 32];
                r_grant_id <= w_idx;
            end else if (r_state == EXEC) begin
                // An unimplemented code reports an error with a clean zero payload.
                r_rsp_result <= w_illegal ? 32'd0 : alu_result;
                r_rsp_zero   <= w_illegal ? 1'b0 : alu_zero;
                r_rsp_err    <= w_illegal;
                r_rsp_valid  <= w_rsp_onehot;
            end else if (w_rsp_done) begin
                r_rsp_valid <= {NUM_REQ{1'b0}};
            end else begin
                r_rsp_valid <= r_rsp_valid;
            end
            r_busy <= (w_next_state != IDLE);
        end
    end

    assign alu_conf   = r_alu_conf;
    assign alu_sign   = r_alu_sign;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign grant_id   = r_grant_id;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter (NUM_REQ=2) with a behavioural ALU attached
// and a scoreboard of expected responses.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [9:0]  req_conf;
    logic [1:0]  req_sign;
    logic [63:0] req_in1, req_in2;
    logic [4:0]  alu_conf;
    logic        alu_sign, alu_zero;
    logic [31:0] alu_in1, alu_in2, alu_result, rsp_result;
    logic        rsp_zero, rsp_err, busy;
    logic [0:0]  grant_id;

    logic [4:0]  conf_a [N];
    logic        sign_a [N];
    logic [31:0] in1_a  [N];
    logic [31:0] in2_a  [N];

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   tb_ptr = 0;
    logic tb_busy = 1'b0;
    int   acc_cnt [N];
    int   snap    [N];
    int   win;
    int   g0;
    logic [1:0] exp_rdy, exp_vld;
    exp_t ent;

    always #5 clk = ~clk;

    assign req_conf = {conf_a[1], conf_a[0]};
    assign req_sign = {sign_a[1], sign_a[0]};
    assign req_in1  = {in1_a[1], in1_a[0]};
    assign req_in2  = {in2_a[1], in2_a[0]};

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_conf(req_conf), .req_sign(req_sign), .req_in1(req_in1), .req_in2(req_in2),
        .alu_conf(alu_conf), .alu_sign(alu_sign), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy), .grant_id(grant_id)
    );

    // Reference ALU; unimplemented codes return junk that must never reach a response.
    function automatic logic [31:0] alu_model(input logic [4:0] c, input logic s,
                                              input logic [31:0] a, input logic [31:0] b);
        case (c)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ~(a | b);
            5'd6:    return a << b[4:0];
            5'd7:    return a >> b[4:0];
            5'd8:    return $unsigned($signed(a) >>> b[4:0]);
            5'd9:    return {31'd0, (s ? ($signed(a) < $signed(b)) : (a < b))};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_model(alu_conf, alu_sign, alu_in1, alu_in2);
    assign alu_zero   = (alu_conf > 5'd9) ? 1'b1 : (alu_result == 32'd0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: checks ready/busy/response every cycle against the reference model.
    always @(negedge clk) begin
        if (reset) begin
            cyc = cyc + 1;
            win = -1;
            if (!tb_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(tb_ptr + k) % N]) win = (tb_ptr + k) % N;
                end
            end
            exp_rdy = 2'b00;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, tb_busy);
            exp_vld = 2'b00;
            if (sb_q.size() > 0 && cyc >= sb_q[0].due) exp_vld[sb_q[0].id] = 1'b1;
            chk("rsp_valid", rsp_valid, exp_vld);
            if (exp_vld != 2'b00) begin
                chk("rsp_result", rsp_result, sb_q[0].res);
                chk("rsp_zero", rsp_zero, sb_q[0].zero);
                chk("rsp_err", rsp_err, sb_q[0].err);
                chk("grant_id", grant_id, sb_q[0].id);
                if (rsp_ready[sb_q[0].id]) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                    tb_ptr = (sb_q[0].id + 1) % N;
`endif
                    void'(sb_q.pop_front());
                    tb_busy = 1'b0;
                end
            end
            if (win >= 0) begin
                ent.id   = win;
                ent.err  = (conf_a[win] > 5'd9);
                ent.res  = ent.err ? 32'd0 : alu_model(conf_a[win], sign_a[win], in1_a[win], in2_a[win]);
                ent.zero = ent.err ? 1'b0 : (ent.res == 32'd0);
                ent.due  = cyc + 2;
                sb_q.push_back(ent);
                tb_busy = 1'b1;
                acc_cnt[win]++;
                grant_log.push_back(win);
            end
        end
    end

    task automatic set_op(input int i, input logic [4:0] c, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        conf_a[i] = c; sign_a[i] = s; in1_a[i] = a; in2_a[i] = b;
    endtask

    task automatic req_on(input int i);
        snap[i] = acc_cnt[i];
        req_valid[i] = 1'b1;
    endtask

    // Wait for requester i to be accepted, then drop its valid.
    task automatic wait_acc(input int i);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            if (acc_cnt[i] != snap[i]) begin
                #1 req_valid[i] = 1'b0;
                return;
            end
        end
        chk("acc_timeout", acc_cnt[i] - snap[i], 1);
        #1 req_valid[i] = 1'b0;
    endtask

    // Wait for the next response and compare it against literal expectations.
    task automatic wait_rsp(input string tag, input int id, input logic [31:0] res,
                            input logic z, input logic e);
        logic [1:0] oh;
        oh = 2'b00;
        oh[id] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                chk({tag, "_vld"}, rsp_valid, oh);
                chk({tag, "_res"}, rsp_result, res);
                chk({tag, "_zero"}, rsp_zero, z);
                chk({tag, "_err"}, rsp_err, e);
                @(posedge clk); #1;
                return;
            end
        end
        chk({tag, "_timeout"}, rsp_valid, oh);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!tb_busy && sb_q.size() == 0) break;
        end
        chk("idle_timeout", {31'd0, busy}, 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        sb_q.delete();
        tb_busy = 1'b0;
        tb_ptr = 0;
        req_valid = 2'b00;
        #1;
        chk({tag, "_valid"}, rsp_valid, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        rsp_ready = 2'b11;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < N; i++) begin
            set_op(i, 5'd0, 1'b0, 32'd0, 32'd0);
            acc_cnt[i] = 0;
            snap[i] = 0;
        end
        #2;
        chk("rst_valid", rsp_valid, 2'b00);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", rsp_zero, 1'b0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_conf", alu_conf, 5'd0);
        chk("rst_sign", alu_sign, 1'b0);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_in2", alu_in2, 32'd0);
        chk("rst_gid", grant_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic add, then a lone req1 op so the pointer comes back to 0.
        set_op(0, ALU_ADD, 1'b0, 32'd5, 32'd7);
        req_on(0); wait_acc(0);
        wait_rsp("add", 0, 32'd12, 1'b0, 1'b0);
        wait_idle();
        set_op(1, ALU_OR, 1'b0, 32'hF0, 32'h0F);
        req_on(1); wait_acc(1);
        wait_rsp("or", 1, 32'hFF, 1'b0, 1'b0);
        wait_idle();

        // Two rounds of simultaneous requests.
        g0 = grant_log.size();
        for (int r = 0; r < 2; r++) begin
            set_op(0, ALU_SUB, 1'b1, 32'd3, 32'd3);
            set_op(1, ALU_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1);
            req_on(0); req_on(1);
            wait_acc(0);
            wait_rsp("pair_a", 0, 32'd0, 1'b1, 1'b0);
            wait_acc(1);
            wait_rsp("pair_b", 1, 32'd1, 1'b0, 1'b0);
            wait_idle();
        end
        chk("pair_n", grant_log.size() - g0, 4);
        if (grant_log.size() >= g0 + 4) begin
            chk("pair_g0", grant_log[g0], 0);
            chk("pair_g1", grant_log[g0 + 1], 1);
            chk("pair_g2", grant_log[g0 + 2], 0);
            chk("pair_g3", grant_log[g0 + 3], 1);
        end

        // Both requesters continuously valid for three arbitrations.
        set_op(0, ALU_XOR, 1'b0, 32'hA5, 32'h5A);
        set_op(1, ALU_SLL, 1'b0, 32'd1, 32'd4);
        g0 = grant_log.size();
        req_valid = 2'b11;
        repeat (9) @(posedge clk);
        #1 req_valid = 2'b00;
        wait_idle();
        chk("cont_n", grant_log.size() - g0, 3);
        if (grant_log.size() >= g0 + 3) begin
            chk("cont_g0", grant_log[g0], 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("cont_g1", grant_log[g0 + 1], 0);
`else
            chk("cont_g1", grant_log[g0 + 1], 1);
`endif
            chk("cont_g2", grant_log[g0 + 2], 0);
        end

        // Illegal code followed by a legal one.
        set_op(0, 5'd12, 1'b0, 32'd123, 32'd456);
        req_on(0); wait_acc(0);
        wait_rsp("illegal", 0, 32'd0, 1'b0, 1'b1);
        wait_idle();
        set_op(1, ALU_AND, 1'b0, 32'hFF, 32'h0F);
        req_on(1); wait_acc(1);
        wait_rsp("legal", 1, 32'h0F, 1'b0, 1'b0);
        wait_idle();

        // Response stall; the non-granted rsp_ready bit is high and must be ignored.
        rsp_ready = 2'b10;
        set_op(0, ALU_OR, 1'b0, 32'hF0, 32'h0F);
        set_op(1, ALU_NOR, 1'b0, 32'd0, 32'd0);
        req_on(0); wait_acc(0);
        wait_rsp("stall", 0, 32'hFF, 1'b0, 1'b0);
        req_on(1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_vld", rsp_valid, 2'b01);
            chk("stall_res", rsp_result, 32'hFF);
            chk("stall_rdy", req_ready, 2'b00);
            chk("stall_busy", busy, 1'b1);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        wait_acc(1);
        wait_idle();

        // Reset while EXEC with the pointer at 1; afterwards req0 must win.
        set_op(0, ALU_ADD, 1'b0, 32'd1, 32'd1);
        req_on(0); wait_acc(0);
        wait_idle();
        req_on(1); wait_acc(1);
        reset_pulse("rst_exec");
        g0 = grant_log.size();
        repeat (3) @(negedge clk);
        chk("rst_exec_stale", rsp_valid, 2'b00);
        @(posedge clk); #1;
        req_on(0); req_on(1);
        wait_acc(0); wait_acc(1);
        wait_idle();
        chk("rst_exec_n", grant_log.size() - g0, 2);
        if (grant_log.size() >= g0 + 1) chk("rst_exec_ptr", grant_log[g0], 0);

        // Reset while RESP.
        rsp_ready = 2'b00;
        req_on(0); wait_acc(0);
        @(posedge clk); #1;
        chk("rst_resp_pre", rsp_valid, 2'b01);
        reset_pulse("rst_resp");
        repeat (4) @(negedge clk);
        chk("rst_resp_stale", rsp_valid, 2'b00);
        @(posedge clk); #1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
